sram_line_packer: RTL and testbench
===================================

// Module: sram_line_packer
// PURPOSE
//  Upstream write stage for the 512b x 128 dual-port tile SRAM: packs a valid/ready stream of
//  narrow words into full LINE_W lines and writes each line through one SRAM port (A/I/CSB/WEB/OEB).
//  A start pulse loads a base address and a line count; done pulses once the last line is written.
//  Sits between the DRAM/feature-map input stream and the Winograd tile buffer; one instance per port.
// PARAMETERS
//  IN_W    64    input word width; LINE_W % IN_W == 0
//  LINE_W  512   SRAM word width
//  ADDR_W  7     SRAM address width
//  DEPTH   128   SRAM words (2**ADDR_W)
// PORTS
//  clock         in   1       single clock; also drives the SRAM CE pin of the written port
//  reset         in   1       synchronous, active-high
//  start         in   1       1-cycle pulse; ignored unless idle
//  base_addr     in   ADDR_W  first line address, sampled on start
//  num_lines     in   ADDR_W+1  lines to write (0..DEPTH), sampled on start
//  in_valid      in   1       input word valid
//  in_data       in   IN_W    input word; word k of a line -> bits [k*IN_W +: IN_W]
//  in_last       in   1       last word of the tile (qualified by in_valid & in_ready)
//  in_ready      out  1       packer accepts a word this cycle
//  sram_a        out  ADDR_W  SRAM address
//  sram_i        out  LINE_W  SRAM write data
//  sram_csb      out  1       SRAM chip select, active-low
//  sram_web      out  1       SRAM write enable, active-low
//  sram_oeb      out  1       SRAM output enable, held 1 (write-only port)
//  busy          out  1       high from start accept until done
//  done          out  1       1-cycle pulse, tile complete
//  short_tile    out  1       sticky until next start: in_last arrived before num_lines filled
// BEHAVIOUR
//  Reset: in_ready=0, sram_csb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_i=0, busy=0, done=0,
//   short_tile=0; FSM->IDLE; lane/line counters=0; partial line discarded, no SRAM write issued.
//  All outputs registered. LANES=LINE_W/IN_W (8). Transfer = in_valid & in_ready.
//  FSM IDLE -> FILL on start (num_lines!=0); IDLE -> DONE on start with num_lines==0.
//   FILL: in_ready=1; each transfer writes lane[lane_cnt], lane_cnt++.
//   On transfer with lane_cnt==LANES-1: next cycle sram_csb=0, sram_web=0 for exactly 1 cycle,
//   sram_a=base_addr+line_cnt (mod DEPTH, wraps 127->0), sram_i=assembled line; lane_cnt=0,
//   line_cnt++. Back-to-back lines allowed: throughput 1 word/cycle, no bubble between lines.
//   SRAM samples on the following posedge clock, so write latency = 2 edges from last-word transfer.
//   line_cnt reaching num_lines (on that final write) -> DONE; in_ready=0 from the cycle after
//   the final transfer.
//   in_last with lane_cnt<LANES-1 or line_cnt<num_lines-1: unfilled lanes zero-padded, that line
//   written normally, short_tile=1, -> DONE. in_last on the final word: normal, short_tile=0.
//  DONE: done=1 one cycle, busy=0, -> IDLE. start in FILL/DONE ignored (no reload, no restart).
//  sram_csb=1/sram_web=1 whenever no write is issued; sram_a/sram_i hold last values.
//  Reset mid-tile: any write scheduled for the next cycle is cancelled; SRAM contents already
//   written are left as-is.
// STRUCTURE
//  Shared package (tile_buf_pkg): LINE_W, IN_W, LANES, ADDR_W, DEPTH constants and the
//   packer state enum {IDLE, FILL, DONE}.
//  One sub-module natural: line_assembler (lane register + lane counter + zero-pad on flush);
//   FSM, address generation and SRAM pin drive stay in sram_line_packer.
// TESTING (bench instantiates the SRAM model on the same clock; read back via the other port)
//  1 start base=0 num=2, 16 words 0x0..0xF continuous -> writes at A=0,1, line0 lane k = k,
//    line1 lane k = 8+k; done 1 cycle after the 2nd write; short_tile=0.
//  2 base=126 num=4, random in_valid gaps -> writes at A=126,127,0,1 in order; csb low exactly
//    4 cycles total; data matches stream.
//  3 base=10 num=3, in_last on word 11 -> A=10 full, A=11 lanes0-3 data / lanes4-7 zero;
//    no write to A=12; short_tile=1; done.
//  4 num=0 start -> done pulse, in_ready never high, csb stays 1.
//  5 reset asserted the cycle after the 8th word of line 0 -> no write at base; outputs at reset
//    values next cycle; a new start then works normally.
//  6 start pulsed again during FILL -> ignored; line count and addresses from first start only.

Source files
------------

// File: rtl/tile_buf_pkg.sv
// Shared constants and packer state encoding for the tile-buffer SRAM write path.
package tile_buf_pkg;

  localparam int IN_W   = 64;
  localparam int LINE_W = 512;
  localparam int LANES  = LINE_W / IN_W;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } packer_state_e;

endpackage

// File: rtl/sram_line_packer_line_assembler.sv
// Collects IN_W words into one LINE_W line; lanes not yet written in the
// current line always read as zero, so an early flush is zero-padded.
module line_assembler
  import tile_buf_pkg::*;
#(
  parameter int IN_W   = tile_buf_pkg::IN_W,
  parameter int LINE_W = tile_buf_pkg::LINE_W
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  wr_en,
  input  logic                                  flush,
  input  logic [IN_W-1:0]                       wr_data,
  output logic [LINE_W-1:0]                     line_out,
  output logic [$clog2(LINE_W/IN_W)-1:0]        lane_cnt
);

  localparam int LANES = LINE_W / IN_W;
  localparam int CNT_W = $clog2(LANES);

  logic [IN_W-1:0] lanes [LANES];

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_cnt <= '0;
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
    end else if (wr_en) begin
      lanes[lane_cnt] <= wr_data;
      lane_cnt        <= flush ? '0 : lane_cnt + CNT_W'(1);
    end
  end

  // Line as it will look including the word being accepted this cycle.
  always_comb begin
    line_out = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < lane_cnt)       line_out[k*IN_W +: IN_W] = lanes[k];
      else if (CNT_W'(k) == lane_cnt) line_out[k*IN_W +: IN_W] = wr_data;
    end
  end

endmodule

// File: rtl/sram_line_packer.sv
// Packs a valid/ready word stream into full SRAM lines and drives one SRAM
// write port; start loads base address and line count, done marks completion.
module sram_line_packer
  import tile_buf_pkg::*;
#(
  parameter int IN_W   = tile_buf_pkg::IN_W,
  parameter int LINE_W = tile_buf_pkg::LINE_W,
  parameter int ADDR_W = tile_buf_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_lines,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [LINE_W-1:0]   sram_i,
  output logic                sram_csb,
  output logic                sram_web,
  output logic                sram_oeb,
  output logic                busy,
  output logic                done,
  output logic                short_tile,
  output packer_state_e       dbg_state
);

  localparam int LANES = LINE_W / IN_W;
  localparam int CNT_W = $clog2(LANES);

  // Handshake: a word moves only on a cycle where in_valid and in_ready are
  // both high; in_ready is registered and high exactly while in FILL.
  packer_state_e state, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d, line_cnt, line_cnt_d;
  logic [ADDR_W-1:0] a_d;
  logic [LINE_W-1:0] i_d, line_out;
  logic [CNT_W-1:0]  lane_cnt;
  logic ready_d, csb_q, csb_d, web_q, web_d, busy_d, done_d, short_d, clear;
  logic xfer, lane_full, last_line, line_done, final_line;

  assign xfer       = in_valid & in_ready;
  assign lane_full  = (lane_cnt == CNT_W'(LANES - 1));
  assign last_line  = (line_cnt == num_q - 1'b1);
  assign line_done  = xfer & (lane_full | in_last);
  assign final_line = line_done & (in_last | last_line);

  line_assembler #(.IN_W(IN_W), .LINE_W(LINE_W)) u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (xfer),
    .flush    (line_done),
    .wr_data  (in_data),
    .line_out (line_out),
    .lane_cnt (lane_cnt)
  );

  always_comb begin
    state_d    = state;
    base_d     = base_q;
    num_d      = num_q;
    line_cnt_d = line_cnt;
    ready_d    = 1'b0;
    a_d        = sram_a;
    i_d        = sram_i;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    busy_d     = busy;
    done_d     = 1'b0;
    short_d    = short_tile;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          base_d     = base_addr;
          num_d      = num_lines;
          line_cnt_d = '0;
          short_d    = 1'b0;
          busy_d     = 1'b1;
          if (num_lines == '0) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            ready_d = 1'b1;
          end
        end
      end
      FILL: begin
        ready_d = 1'b1;
        if (line_done) begin
          csb_d      = 1'b0;
          web_d      = 1'b0;
          a_d        = base_q + line_cnt[ADDR_W-1:0];
          i_d        = line_out;
          line_cnt_d = line_cnt + 1'b1;
          if (final_line) begin
            state_d = DONE;
            ready_d = 1'b0;
            short_d = in_last & ~(lane_full & last_line);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      line_cnt   <= '0;
      in_ready   <= 1'b0;
      sram_a     <= '0;
      sram_i     <= '0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      short_tile <= 1'b0;
    end else begin
      state      <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      line_cnt   <= line_cnt_d;
      in_ready   <= ready_d;
      sram_a     <= a_d;
      sram_i     <= i_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      busy       <= busy_d;
      done       <= done_d;
      short_tile <= short_d;
    end
  end

  // Reset arriving while a write sits on the pins must stop the SRAM from
  // sampling it at the next edge, so the strobes are gated directly.
  assign sram_csb  = csb_q | reset;
  assign sram_web  = web_q | reset;
  assign sram_oeb  = 1'b1;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_line_packer.sv
// Bench for sram_line_packer: SRAM model on the write port, expected writes
// queued at stimulus time and compared when the strobes fire.
module tb_sram_line_packer;
  import tile_buf_pkg::*;

  localparam int AW = ADDR_W;
  typedef logic [AW+LINE_W-1:0] wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_lines = '0;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [AW-1:0]     sram_a;
  logic [LINE_W-1:0] sram_i;
  logic              sram_csb, sram_web, sram_oeb, busy, done, short_tile;
  packer_state_e     dbg_state;

  sram_line_packer dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .sram_a(sram_a), .sram_i(sram_i),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .busy(busy), .done(done), .short_tile(short_tile), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int csb_cnt = 0;
  int rdy_cnt = 0;
  wr_t exp_q[$];
  logic [LINE_W-1:0] mem [DEPTH];

  task automatic check(input string tag, input logic [519:0] got, input logic [519:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clock) begin
    cyc++;
    if (!sram_csb && !sram_web) mem[sram_a] <= sram_i;
  end

  // Scoreboard: every write strobe pops the oldest expected write.
  always @(negedge clock) begin
    wr_t e;
    if (in_ready) rdy_cnt++;
    if (!sram_csb) csb_cnt++;
    if (!sram_csb && !sram_web) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("sram_wr", {sram_a, sram_i}, e);
      last_wr_cyc = cyc;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; num_lines = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input logic last);
    int waited = 0;
    logic rdy;
    in_valid = 1'b1; in_data = d; in_last = last;
    forever begin
      rdy = in_ready;
      @(posedge clock);
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        check("in_ready_wait", rdy, 1'b1);
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int n = 0;
    while (!done && n < 100) begin @(negedge clock); n++; end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    dcyc = cyc;
    @(negedge clock);
    check("done_pulse", done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 1'b0);
    check({tag, "_csb"},   sram_csb, 1'b1);
    check({tag, "_web"},   sram_web, 1'b1);
    check({tag, "_oeb"},   sram_oeb, 1'b1);
    check({tag, "_a"},     sram_a, '0);
    check({tag, "_i"},     sram_i, '0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_short"}, short_tile, 1'b0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic run_tile(input string tag, input logic [AW-1:0] b, input int n, input int nw,
                          input bit use_last, input bit gaps, input bit pattern, input bit restart);
    logic [IN_W-1:0]   w [$];
    logic [LINE_W-1:0] ln;
    int nl = 0;
    int dcyc;
    for (int i = 0; i < nw; i++) w.push_back(pattern ? IN_W'(i) : {$urandom, $urandom});
    for (int l = 0; l * LANES < nw; l++) begin
      ln = '0;
      for (int k = 0; k < LANES; k++)
        if (l * LANES + k < nw) ln[k*IN_W +: IN_W] = w[l*LANES + k];
      exp_q.push_back({AW'(int'(b) + l), ln});
      nl++;
    end
    csb_cnt = 0; rdy_cnt = 0;
    do_start(b, (AW+1)'(n));
    for (int i = 0; i < nw; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
      if (restart && i == 3) begin
        start = 1'b1; base_addr = 7'd50; num_lines = 8'd5;
        @(negedge clock);
        start = 1'b0;
      end
      send_word(w[i], use_last && (i == nw - 1));
    end
    wait_done(dcyc);
    check({tag, "_q_drain"}, exp_q.size(), 0);
    check({tag, "_csb_cycles"}, csb_cnt, nl);
    check({tag, "_short"}, short_tile, (use_last && nw < n * LANES) ? 1'b1 : 1'b0);
    if (nl > 0) check({tag, "_done_lat"}, dcyc - last_wr_cyc, 1);
    else        check({tag, "_no_ready"}, rdy_cnt, 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("rst");
    @(negedge clock);

    run_tile("t1", 7'd0, 2, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_mem1_lane5", mem[1][5*IN_W +: IN_W], IN_W'(13));
    run_tile("t2", 7'd126, 4, 32, 1'b0, 1'b1, 1'b0, 1'b0);
    run_tile("t3", 7'd10, 3, 12, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_no_a12", mem[12], '0);
    run_tile("t4", 7'd5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset lands while the first line's write is on the pins.
    csb_cnt = 0;
    do_start(7'd20, 8'd2);
    for (int i = 0; i < 7; i++) send_word({$urandom, $urandom}, 1'b0);
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    @(posedge clock);
    #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    check("t5_csb_gated", sram_csb, 1'b1);
    @(negedge clock);
    check_reset_outputs("t5");
    reset = 1'b0;
    @(negedge clock);
    check("t5_no_write", csb_cnt, 0);
    check("t5_mem20", mem[20], '0);
    run_tile("t5b", 7'd30, 1, 8, 1'b0, 1'b1, 1'b0, 1'b0);

    run_tile("t6", 7'd40, 2, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_no_a42", mem[42], '0);
    check("t6_no_a50", mem[50], '0);

    dummy = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
